ps2_keycode_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_frame_rx.sv | 106 ++++++++++
 rtl/ps2_keycode_rx.sv | 66 ++++++
 tb/tb_ps2_keycode_rx.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scan-code set 2 constants, frame FSM states and keycode type.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

    typedef logic [8:0] keycode_t;

    // Keyboard status/control bytes that never name a key
    function automatic logic is_discard(input logic [7:0] b);
        return b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronizes and filters the PS/2 lines and assembles 11-bit frames into bytes.
// Optional PS2_TIMEOUT_EN aborts a frame stalled for TIMEOUT_CYC cycles.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frameErr
);

    localparam int FW = $clog2(FILTER_LEN);

    logic [1:0]    clk_s, dat_s;
    logic [FW-1:0] fcnt;
    logic          filt, filt_d, strobe, d, tmo;
    frame_state_t  state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par;

    assign d          = dat_s[1];
    assign strobe     = filt_d & ~filt;
    assign rx_byte    = shreg;
    assign byte_valid = strobe && state == STOP && d && ^{shreg, par};

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            clk_s  <= '1;
            dat_s  <= '1;
            fcnt   <= '0;
            filt   <= 1'b1;
            filt_d <= 1'b1;
        end else begin
            clk_s  <= {clk_s[0], ps2_clk};
            dat_s  <= {dat_s[0], ps2_dat};
            filt_d <= filt;
            if (clk_s[1] == filt)
                fcnt <= '0;
            else if (fcnt == FW'(FILTER_LEN - 1)) begin
                fcnt <= '0;
                filt <= clk_s[1];
            end else
                fcnt <= fcnt + 1'b1;
        end

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or negedge resetN)
        if (!resetN)
            tcnt <= '0;
        else
            tcnt <= (state == IDLE || strobe || tmo) ? '0 : tcnt + 1'b1;

    assign tmo = (tcnt == TW'(TIMEOUT_CYC)) && !strobe;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            state    <= IDLE;
            bitcnt   <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            frameErr <= 1'b0;
            if (tmo) begin
                state    <= IDLE;
                frameErr <= 1'b1;
            end else if (strobe)
                case (state)
                    IDLE:
                        if (!d) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end
                    DATA: begin
                        shreg  <= {d, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= d;
                        state <= STOP;
                    end
                    STOP: begin
                        frameErr <= !(d && ^{shreg, par});
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
        end

endmodule

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 receiver that folds E0/F0 prefixes into a 9-bit keycode with make/brakee pulses.
// Build with PS2_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYC cycles.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [8:0] keyCode,
    output logic       make,
    output logic       brakee,
    output logic       frameErr
);

    logic [7:0] rx_byte;
    logic       byte_valid, ext, brk;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_frame (
        .clk       (clk),
        .resetN    (resetN),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frameErr  (frameErr)
    );

    // Prefix flags accumulate independently, so E0/F0 order does not matter
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            keyCode <= '0;
            make    <= 1'b0;
            brakee  <= 1'b0;
            ext     <= 1'b0;
            brk     <= 1'b0;
        end else begin
            make   <= 1'b0;
            brakee <= 1'b0;
            if (byte_valid) begin
                if (rx_byte == PS2_EXT)
                    ext <= 1'b1;
                else if (rx_byte == PS2_BRK)
                    brk <= 1'b1;
                else begin
                    if (!is_discard(rx_byte)) begin
                        keyCode <= keycode_t'({ext, rx_byte});
                        make    <= !brk;
                        brakee  <= brk;
                    end
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end else if (frameErr) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb_ps2_keycode_rx: directed PS/2 frames with a queue-based scoreboard checking keyCode/make/brakee/frameErr.
module tb_ps2_keycode_rx;

    localparam int FL = 8;
    localparam int TO = 300;
    localparam int H  = 20;

    logic       clk = 1'b0, resetN = 1'b0, ps2_clk = 1'b1, ps2_dat = 1'b1;
    logic [8:0] keyCode;
    logic       make, brakee, frameErr;

    ps2_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .resetN(resetN), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .keyCode(keyCode), .make(make), .brakee(brakee), .frameErr(frameErr)
    );

    always #10 clk = ~clk;

    typedef enum int {EV_MAKE, EV_BRK, EV_ERR} ev_t;
    typedef struct {
        ev_t        kind;
        logic [8:0] code;
        bit         lat;
    } exp_t;

    exp_t       q[$];
    int         errors = 0, checks = 0, cyc = 0, stop_cyc = 0;
    logic [8:0] last = '0;
    bit         pulse_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output pulse must match the next queued expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        ev_t  k;
        if (resetN) begin
            if (pulse_seen) check("pulse_width", {make, brakee, frameErr}, 3'b000);
            pulse_seen = make | brakee | frameErr;
            if (make | brakee | frameErr) begin
                check("make_brakee_exclusive", make & brakee, 1'b0);
                k = make ? EV_MAKE : brakee ? EV_BRK : EV_ERR;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got kind %0d keyCode %0h expected no output", k, keyCode);
                end else begin
                    e = q.pop_front();
                    check("kind", k, e.kind);
                    check("keyCode", keyCode, e.code);
                    if (e.lat) check("latency", cyc - stop_cyc, FL + 3);
                end
            end
        end else
            pulse_seen = 0;
    end

    task automatic expect_key(input logic [8:0] c, input bit brk);
        q.push_back('{brk ? EV_BRK : EV_MAKE, c, 1'b1});
        last = c;
    endtask

    task automatic expect_err(input bit lat);
        q.push_back('{EV_ERR, last, lat});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives frame bits first..lastb; optional 3-cycle low glitch in the high phase of bit gl
    task automatic send_bits(input logic [7:0] b, input bit bad, input int gl, input int first, input int lastb);
        logic [10:0] f;
        f = {1'b1, ~^b ^ bad, b, 1'b0};
        for (int i = first; i <= lastb; i++) begin
            ps2_dat = f[i];
            if (i == gl) begin
                wait_cyc(5);
                ps2_clk = 1'b0;
                wait_cyc(3);
                ps2_clk = 1'b1;
                wait_cyc(H - 8);
            end else
                wait_cyc(H);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            wait_cyc(H);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        wait_cyc(H);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b0, -1, 0, 10);
    endtask

    initial begin
        wait_cyc(5);
        check("reset_keyCode", keyCode, 9'h000);
        check("reset_pulses", {make, brakee, frameErr}, 3'b000);
        resetN = 1'b1;
        wait_cyc(5);

        expect_key(9'h01C, 0); send(8'h1C);
        send(8'hF0); expect_key(9'h01C, 1); send(8'h1C);
        send(8'hE0); expect_key(9'h175, 0); send(8'h75);
        send(8'hE0); send(8'hF0); expect_key(9'h175, 1); send(8'h75);
        send(8'hF0); send(8'hE0); expect_key(9'h16B, 1); send(8'h6B);
        send(8'hAA); send(8'hF0); send(8'hFA); expect_key(9'h029, 0); send(8'h29);
        expect_key(9'h029, 0); send(8'h29);
        expect_key(9'h029, 0); send(8'h29);

        expect_err(1); send_bits(8'h16, 1'b1, -1, 0, 10);
        check("keyCode_held_after_err", keyCode, 9'h029);
        expect_key(9'h016, 0); send(8'h16);
        send(8'hF0); expect_err(1); send_bits(8'h5A, 1'b1, -1, 0, 10);
        expect_key(9'h05A, 0); send(8'h5A);

        ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1; wait_cyc(H);
        expect_key(9'h01C, 0); send_bits(8'h1C, 1'b0, 3, 0, 10);

        send(8'hF0);
        send_bits(8'h33, 1'b0, -1, 0, 4);
        resetN = 1'b0;
        wait_cyc(3);
        check("midframe_reset_keyCode", keyCode, 9'h000);
        check("midframe_reset_pulses", {make, brakee, frameErr}, 3'b000);
        last = '0;
        resetN = 1'b1;
        wait_cyc(5);
        expect_key(9'h033, 0); send(8'h33);

        send_bits(8'h1C, 1'b0, -1, 0, 4);
`ifdef PS2_TIMEOUT_EN
        expect_err(0);
        wait_cyc(TO + 10);
        expect_key(9'h01C, 0); send(8'h1C);
`else
        wait_cyc(TO + 10);
        expect_key(9'h01C, 0); send_bits(8'h1C, 1'b0, -1, 5, 10);
`endif

        wait_cyc(100);
        check("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
